// File: rtl/game_flow_controller.sv
// Game-flow FSM: menu, per-level load/play, held OVER/PASS screens, lives,
// optional level timer and final clear screen.
module game_flow_controller #(
    parameter int unsigned NUM_LEVELS   = 4,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned LEVEL_FRAMES = 0,
    parameter int unsigned HOLD_FRAMES  = 60,
    localparam int unsigned LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_tick,
    input  logic          start_btn,
    input  logic          gameover,
    input  logic          gamewin,
    output logic          revive,
    output logic [LW-1:0] level,
    output logic [3:0]    lives_left,
    output logic [15:0]   time_left,
    output logic [2:0]    state_code,
    output logic          in_play
);

    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [2:0] {
        StMenu  = 3'd0,
        StLoad  = 3'd1,
        StPlay  = 3'd2,
        StOver  = 3'd3,
        StPass  = 3'd4,
        StClear = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [3:0]    lives_q, lives_d;
    logic [15:0]   time_q, time_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          btn_prev_q;
    logic          revive_q;

    logic start_edge, hold_done, timer_on, timeout, last_level;

    assign start_edge = start_btn & ~btn_prev_q;
    assign hold_done  = (hold_q == HW'(HOLD_FRAMES));
    assign timer_on   = (LEVEL_FRAMES != 0);
    assign timeout    = timer_on && frame_tick && (time_q == 16'd1);
    assign last_level = (level_q == LW'(NUM_LEVELS - 1));

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StMenu;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StMenu:  if (start_edge) state_d = StLoad;
            StLoad:  state_d = StPlay;
            StPlay: begin
                if (gameover)     state_d = StOver;
                else if (gamewin) state_d = StPass;
                else if (timeout) state_d = StOver;
            end
            StOver: begin
                if (hold_done) begin
                    if (lives_q == 4'd0) state_d = StMenu;
                    else if (start_edge) state_d = StLoad;
                end
            end
            StPass:  if (hold_done) state_d = last_level ? StClear : StLoad;
            StClear: if (start_edge) state_d = StMenu;
            default: state_d = StMenu;
        endcase
    end

    // Datapath next values, keyed off the current and next state
    always_comb begin
        level_d = level_q;
        lives_d = lives_q;
        time_d  = time_q;
        hold_d  = hold_q;
        if (state_q == StMenu && state_d == StLoad) begin
            level_d = '0;
            lives_d = 4'(LIVES);
        end
        if (state_q == StLoad) begin
            time_d = 16'(LEVEL_FRAMES);
        end
        if (state_q == StPlay) begin
            if (state_d == StOver && lives_q != 4'd0) begin
                lives_d = lives_q - 4'd1;
            end
            // Timeout lands on zero through the same decrement
            if (!gameover && !gamewin && timer_on && frame_tick && time_q != 16'd0) begin
                time_d = time_q - 16'd1;
            end
        end
        if (state_q == StPass && state_d == StLoad) begin
            level_d = level_q + LW'(1);
        end
        if (state_d != state_q) begin
            hold_d = '0;
        end else if ((state_q == StOver || state_q == StPass) && frame_tick && !hold_done) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            level_q    <= '0;
            lives_q    <= 4'(LIVES);
            time_q     <= '0;
            hold_q     <= '0;
            btn_prev_q <= 1'b1;
            revive_q   <= 1'b0;
        end else begin
            level_q    <= level_d;
            lives_q    <= lives_d;
            time_q     <= time_d;
            hold_q     <= hold_d;
            btn_prev_q <= start_btn;
            revive_q   <= (state_d == StLoad);
        end
    end

    // Outputs
    always_comb begin
        revive     = revive_q;
        level      = level_q;
        lives_left = lives_q;
        time_left  = time_q;
        state_code = state_q;
        in_play    = (state_q == StPlay);
    end

endmodule
